// File: rtl/spi_bus_bridge.sv
// SPI slave to parallel bus bridge.
// Frames command, address and data words; supports burst and read prefetch.

module spi_bus_bridge #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_cs,
    input  logic                         i_sck,
    input  logic                         i_mosi,
    output logic                         o_miso,
    output logic [7:0]                   o_command,
    output logic [ADDRESS_BUS_WIDTH-1:0] o_address,
    output logic [DATA_BUS_WIDTH-1:0]    o_write_data,
    output logic                         o_transaction_strobe,
    input  logic [DATA_BUS_WIDTH-1:0]    i_read_data
);
    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam int DW = DATA_BUS_WIDTH;
    localparam int HW = (AW > DW) ? AW : DW;
    localparam int MW = (HW > 8) ? HW : 8;
    localparam int CW = $clog2(MW + 1);

    typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;
    state_t state, state_nx;

    logic [2:0]    cs_q;
    logic [2:0]    sck_q;
    logic [1:0]    mosi_q;
    logic          cs_s;
    logic          cs_fall;
    logic          sck_rise;
    logic          sck_fall;
    logic          mosi_s;

    logic [CW-1:0] cnt;
    logic [CW-1:0] last_cnt;
    logic          bit_last;
    logic [MW-2:0] in_sr;
    logic [MW-1:0] in_next;
    logic [DW-1:0] miso_sr;
    logic [DW-1:0] rd_word;
    logic          rd_pend;
    logic          first_wr;
    logic          strobe;
    logic [1:0]    stb_d;
    logic [7:0]    cmd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_q   <= 3'b111;
            sck_q  <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            cs_q   <= {cs_q[1:0], i_cs};
            sck_q  <= {sck_q[1:0], i_sck};
            mosi_q <= {mosi_q[0], i_mosi};
        end
    end

    assign cs_s     = cs_q[1];
    assign cs_fall  = cs_q[2] & ~cs_q[1];
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign mosi_s   = mosi_q[1];
    assign in_next  = {in_sr, mosi_s};

    // Frame phase register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Phase length, last-bit detect and next phase; CS high aborts.
    always_comb begin
        last_cnt = '0;
        case (state)
            CMD:     last_cnt = CW'(7);
            ADDR:    last_cnt = CW'(AW - 1);
            DATA:    last_cnt = CW'(DW - 1);
            default: last_cnt = '0;
        endcase
        bit_last = (state != IDLE) && !cs_s && sck_rise && (cnt == last_cnt);
        state_nx = state;
        case (state)
            IDLE:    if (cs_fall) state_nx = CMD;
            CMD:     if (cs_s) state_nx = IDLE;
                     else if (bit_last) state_nx = ADDR;
            ADDR:    if (cs_s) state_nx = IDLE;
                     else if (bit_last) state_nx = DATA;
            DATA:    if (cs_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shifting, field latching, strobes, read capture and MISO shifter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            in_sr    <= '0;
            miso_sr  <= '0;
            rd_word  <= '0;
            rd_pend  <= 1'b0;
            first_wr <= 1'b1;
            strobe   <= 1'b0;
            stb_d    <= 2'b00;
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            strobe <= 1'b0;
            stb_d  <= {stb_d[0], strobe};
            if (stb_d[1]) begin
                rd_word <= i_read_data;
                rd_pend <= 1'b1;
            end
            if (state == IDLE || cs_s) begin
                cnt      <= '0;
                in_sr    <= '0;
                miso_sr  <= '0;
                rd_pend  <= 1'b0;
                first_wr <= 1'b1;
            end else begin
                if (sck_rise) begin
                    in_sr <= in_next[MW-2:0];
                    cnt   <= bit_last ? '0 : cnt + 1'b1;
                end
                if (bit_last) begin
                    case (state)
                        CMD: cmd_q <= in_next[7:0];
                        ADDR: begin
                            addr_q <= in_next[AW-1:0];
                            strobe <= !cmd_q[0];
                        end
                        DATA: begin
                            strobe <= 1'b1;
                            if (cmd_q[0]) begin
                                wdata_q  <= in_next[DW-1:0];
                                first_wr <= 1'b0;
                                if (!first_wr) addr_q <= addr_q + 1'b1;
                            end else begin
                                addr_q <= addr_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (sck_fall) begin
                    if (rd_pend) begin
                        miso_sr <= rd_word;
                        rd_pend <= 1'b0;
                    end else begin
                        miso_sr <= {miso_sr[DW-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign o_miso               = (state == DATA) && !cmd_q[0] && miso_sr[DW-1];
    assign o_command            = cmd_q;
    assign o_address            = addr_q;
    assign o_write_data         = wdata_q;
    assign o_transaction_strobe = strobe;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Randomized bench for spi_bus_bridge against a frame-level model.
// Bench acts as SPI master and as the bus slave answering reads.

module tb_spi_bus_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        miso;
    logic [7:0]  command;
    logic [15:0] address;
    logic [15:0] wdata;
    logic [15:0] rdata = 16'h0;
    logic        strobe;

    always #10 clk = ~clk;

    spi_bus_bridge #(
        .ADDRESS_BUS_WIDTH(16),
        .DATA_BUS_WIDTH(16)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_cs(cs),
        .i_sck(sck),
        .i_mosi(mosi),
        .o_miso(miso),
        .o_command(command),
        .o_address(address),
        .o_write_data(wdata),
        .o_transaction_strobe(strobe),
        .i_read_data(rdata)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  cmd;
        logic        wr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] wdat[$];
    bit          tx_bits[$];
    bit          rx_bits[$];
    int          total = 0;
    int          bad = 0;
    int          nstb = 0;
    logic        prev_stb = 1'b0;
    bit          miso_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem(input logic [15:0] a);
        if (a == 16'h00F1) return 16'h7530;
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Strobe scoreboard and MISO-quiet check, every cycle out of reset.
    always @(negedge clk) begin : chk
        exp_t e;
        if (rst_n) begin
            if (strobe) begin
                nstb++;
                check("strobe_gap", {31'd0, prev_stb}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got strobe at %0h expected none",
                             address);
                end else begin
                    e = exp_q.pop_front();
                    check("stb_addr", address, e.addr);
                    check("stb_cmd", command, e.cmd);
                    if (e.wr) check("stb_wdata", wdata, e.data);
                end
            end
            if (!miso_ok) check("miso_quiet", miso, 32'd0);
        end
        prev_stb = strobe;
    end

    // Bus slave: read word is valid only in the cycle 2 after the strobe.
    always @(negedge clk) begin : slave
        logic        p1v, p2v;
        logic [15:0] p1a, p2a;
        rdata = p2v ? mem(p2a) : 16'($urandom);
        p2v = p1v;
        p2a = p1a;
        p1v = strobe & rst_n;
        p1a = address;
    end

    task automatic build_frame(input logic [7:0] cmd, input logic [15:0] addr,
                               input int nbits);
        logic [15:0] w;
        int          full;
        tx_bits.delete();
        for (int i = 7; i >= 0; i--) tx_bits.push_back(cmd[i]);
        for (int i = 15; i >= 0; i--) tx_bits.push_back(addr[i]);
        for (int k = 0; k < wdat.size(); k++) begin
            w = wdat[k];
            for (int i = 15; i >= 0; i--) tx_bits.push_back(w[i]);
        end
        while (tx_bits.size() < nbits) tx_bits.push_back(1'($urandom));
        while (tx_bits.size() > nbits) void'(tx_bits.pop_back());
        if (nbits >= 24) begin
            full = (nbits - 24) / 16;
            if (cmd[0]) begin
                for (int k = 0; k < full; k++)
                    exp_q.push_back('{16'(addr + k), cmd, 1'b1, wdat[k]});
            end else begin
                for (int k = 0; k <= full; k++)
                    exp_q.push_back('{16'(addr + k), cmd, 1'b0, 16'h0});
            end
        end
    endtask

    task automatic spi_run(input bit keep_low, input bit glitch, input bit is_read);
        int hp;
        hp = $urandom_range(165, 245);
        rx_bits.delete();
        if (glitch) begin
            cs = 1'b0;
            sck = 1'b1;
            #(hp);
            sck = 1'b0;
            #(hp);
        end else begin
            cs = 1'b0;
            #(hp);
        end
        for (int i = 0; i < tx_bits.size(); i++) begin
            mosi = tx_bits[i];
            #(hp);
            sck = 1'b1;
            rx_bits.push_back(miso);
            if (i == 23 && is_read) miso_ok = 1'b1;
            #(hp);
            sck = 1'b0;
        end
        #(hp);
        if (!keep_low) begin
            cs = 1'b1;
            #(2 * hp);
            miso_ok = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr,
                             input int nbits, input bit glitch, output int n);
        int          s0;
        int          nb;
        logic [15:0] got;
        logic [15:0] want;
        s0 = nstb;
        build_frame(cmd, addr, nbits);
        spi_run(1'b0, glitch, !cmd[0]);
        #200;
        check("pending", exp_q.size(), 32'd0);
        exp_q.delete();
        if (!cmd[0]) begin
            for (int k = 0; 24 + 16 * k < nbits; k++) begin
                nb = nbits - 24 - 16 * k;
                if (nb > 16) nb = 16;
                got = '0;
                for (int b = 0; b < nb; b++)
                    got = {got[14:0], 1'(rx_bits[24 + 16 * k + b])};
                want = mem(16'(addr + k)) >> (16 - nb);
                check("miso_word", got, want);
            end
        end
        n = nstb - s0;
    endtask

    initial begin : main
        int          n;
        int          s0;
        logic [15:0] got;
        logic [7:0]  rc;
        logic [15:0] ra;

        #35;
        check("rst_miso", miso, 32'd0);
        check("rst_cmd", command, 32'd0);
        check("rst_addr", address, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_strobe", strobe, 32'd0);
        rst_n = 1'b1;
        #200;

        wdat = '{16'h1234};
        run_frame(8'h03, 16'h00F0, 40, 1'b0, n);
        check("wr_count", n, 32'd1);
        check("wr_cmd", command, 32'h03);
        check("wr_addr", address, 32'h00F0);
        check("wr_data", wdata, 32'h1234);

        wdat = '{};
        run_frame(8'h02, 16'h00F1, 40, 1'b0, n);
        check("rd_count", n, 32'd2);
        got = '0;
        for (int b = 0; b < 16; b++) got = {got[14:0], 1'(rx_bits[24 + b])};
        check("rd_word", got, 32'h7530);

        wdat = '{16'hFFFF, 16'h0001, 16'h0002};
        run_frame(8'h03, 16'h00F0, 72, 1'b0, n);
        check("burst_count", n, 32'd3);
        check("burst_addr", address, 32'h00F2);
        check("burst_data", wdata, 32'h0002);

        wdat = '{16'h1111, 16'h2222};
        run_frame(8'h03, 16'hFFFF, 56, 1'b0, n);
        check("wrap_count", n, 32'd2);
        check("wrap_addr", address, 32'h0000);

        wdat = '{16'h9999};
        run_frame(8'h03, 16'h1234, 30, 1'b0, n);
        check("abort_count", n, 32'd0);
        check("abort_hold", wdata, 32'h2222);
        wdat = '{16'hABCD};
        run_frame(8'h03, 16'h00F0, 40, 1'b0, n);
        check("after_abort", n, 32'd1);
        check("after_abort_data", wdata, 32'hABCD);

        wdat = '{16'h5555};
        run_frame(8'hFD, 16'h0100, 40, 1'b1, n);
        check("glitch_count", n, 32'd1);
        check("glitch_cmd", command, 32'hFD);

        s0 = nstb;
        wdat = '{16'hBEEF};
        build_frame(8'h03, 16'h00AA, 16);
        exp_q.delete();
        spi_run(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #25;
        check("mrst_miso", miso, 32'd0);
        check("mrst_cmd", command, 32'd0);
        check("mrst_addr", address, 32'd0);
        check("mrst_wdata", wdata, 32'd0);
        check("mrst_strobe", strobe, 32'd0);
        cs = 1'b1;
        miso_ok = 1'b0;
        #100;
        rst_n = 1'b1;
        #300;
        check("mrst_nostrobe", nstb - s0, 32'd0);
        wdat = '{16'hCAFE};
        run_frame(8'h03, 16'h00AB, 40, 1'b0, n);
        check("post_rst_count", n, 32'd1);
        check("post_rst_data", wdata, 32'hCAFE);

        for (int r = 0; r < 10; r++) begin
            rc = 8'($urandom);
            ra = (r % 3 == 0) ? 16'hFFFE : 16'($urandom);
            wdat = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            run_frame(rc, ra, $urandom_range(0, 72), 1'($urandom), n);
            #($urandom_range(100, 400));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_bus_bridge.md
SPI_BUS_BRIDGE -- requirements
Module: spi_bus_bridge

Interface
REQ-001 SHALL have parameter ADDRESS_BUS_WIDTH, default 16, the address field width in bits.
REQ-002 SHALL have parameter DATA_BUS_WIDTH, default 16, the data word width in bits.
REQ-003 SHALL have port i_clk, input, 1 bit: the single system clock, 48 MHz; all logic runs on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_cs, input, 1 bit: SPI chip select, active-low, asynchronous to i_clk.
REQ-006 SHALL have port i_sck, input, 1 bit: SPI clock, mode 0, asynchronous to i_clk.
REQ-007 SHALL have port i_mosi, input, 1 bit: SPI data in.
REQ-008 SHALL have port o_miso, output, 1 bit: SPI data out.
REQ-009 SHALL have port o_command, output, 8 bits: the command byte of the current frame.
REQ-010 SHALL have port o_address, output, ADDRESS_BUS_WIDTH bits: the word address of the current transaction.
REQ-011 SHALL have port o_write_data, output, DATA_BUS_WIDTH bits: the write word.
REQ-012 SHALL have port o_transaction_strobe, output, 1 bit: a one-cycle pulse marking one bus transaction.
REQ-013 SHALL have port i_read_data, input, DATA_BUS_WIDTH bits: the read word, valid 2 cycles after the strobe.

Function
REQ-014 SHALL pass i_cs, i_sck and i_mosi through 2-flop synchronizers; SCK edges are detected on the synchronized signal; supported SCK <= 4 MHz.
REQ-015 SHALL frame the serial stream MSB-first as: 8-bit command, then ADDRESS_BUS_WIDTH-bit address, then DATA_BUS_WIDTH-bit data words.
REQ-016 SHALL sample MOSI on the detected SCK rising edge and update MISO on the detected SCK falling edge.
REQ-017 SHALL use states IDLE, CMD, ADDR, DATA; IDLE->CMD on the synchronized CS falling edge; CMD->ADDR after 8 bits; ADDR->DATA after ADDRESS_BUS_WIDTH bits; DATA stays in DATA while CS is low.
REQ-018 SHALL latch o_command when the CMD phase completes and o_address when the ADDR phase completes.
REQ-019 SHALL decode command[1:0]: 00 and 10 are reads, 01 and 11 are writes; command[7:2] is ignored and passed through on o_command.
REQ-020 SHALL, for a write, latch o_write_data and pulse o_transaction_strobe 1 cycle after the last bit of each full data word is sampled.
REQ-021 SHALL, for a read, pulse o_transaction_strobe 1 cycle after the last address bit is sampled, and again 1 cycle after the last bit of each completed data word while CS stays low.
REQ-022 SHALL, for a read, capture i_read_data exactly 2 cycles after each strobe.
REQ-023 SHALL load the captured read word into the MISO shifter on the next detected SCK falling edge, and drive its MSB on o_miso from then on.
REQ-024 SHALL, in burst mode (CS held low past the first data word), increment o_address by 1 after each word's strobe; the address wraps from all-ones to 0.
REQ-025 SHALL drive o_miso to 0 in IDLE, CMD and ADDR, and during write frames.
REQ-026 SHALL, when CS rises mid-word or mid-header, abort the frame: no strobe, partial bits discarded, return to IDLE.
REQ-027 SHALL leave o_command, o_address and o_write_data holding their last values after a frame ends or aborts.
REQ-028 SHALL, when a CS falling edge and an SCK edge are detected in the same cycle, start the frame and ignore that SCK edge.
REQ-029 SHALL never assert o_transaction_strobe for two consecutive cycles.

Reset
REQ-030 SHALL, while i_rst_n = 0, set the state to IDLE, clear the bit counter and shifters, and clear the synchronizers to CS = 1, SCK = 0.
REQ-031 SHALL hold every output at 0 while in reset: o_miso, o_command, o_address, o_write_data, o_transaction_strobe.
REQ-032 SHALL, when reset is asserted mid-frame, abort the frame with no strobe; after release it waits for a fresh CS falling edge.

Verification
REQ-033 Write: cmd 0x03, addr 0x00F0, data 0x1234 -> exactly one strobe; at the strobe o_command = 0x03, o_address = 0x00F0, o_write_data = 0x1234.
REQ-034 Read: cmd 0x02, addr 0x00F1, i_read_data = 0x7530 -> one strobe after the address phase; MISO shifts out 0x7530 MSB-first over the 16 data clocks.
REQ-035 Burst write: cmd 0x03, addr 0x00F0, words 0xFFFF, 0x0001, 0x0002 -> 3 strobes, with addresses 0x00F0, 0x00F1, 0x00F2.
REQ-036 Wrap: burst write at addr 0xFFFF, 2 words -> strobes at addresses 0xFFFF, then 0x0000.
REQ-037 Abort: CS raised after 30 bits of a write -> no strobe, state IDLE; the next full frame completes normally.
REQ-038 Reset: i_rst_n pulsed low during the ADDR phase -> all outputs 0 and no strobe; a subsequent write frame works.
